// File: rtl/register_file_32x32_pkg.sv
`default_nettype none
// ============================================================================
// register_file_32x32_pkg : shared widths and word/address types for the
// register file, datapath and ALU.  Rev 1.0
// ============================================================================
package register_file_32x32_pkg;

    localparam int DATA_INDEX_LIMIT     = 31;
    localparam int REG_ADDR_INDEX_LIMIT = 4;
    localparam int NUM_OF_REG           = 32;

    typedef logic [DATA_INDEX_LIMIT:0]     word_t;
    typedef logic [REG_ADDR_INDEX_LIMIT:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/register_file_32x32_if.sv
`default_nettype none
// ============================================================================
// register_file_32x32_if : read/write request and read-data bundle between the
// datapath (master) and the register file (slave).  Rev 1.0
// ============================================================================
interface register_file_32x32_if
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_W = DATA_INDEX_LIMIT + 1,
    parameter int ADDR_W = REG_ADDR_INDEX_LIMIT + 1
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr_r1;
    logic [ADDR_W-1:0] addr_r2;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic [DATA_W-1:0] data_r1;
    logic [DATA_W-1:0] data_r2;

    modport master (
        output read, write, addr_r1, addr_r2, addr_w, data_w,
        input  data_r1, data_r2
    );

    modport slave (
        input  read, write, addr_r1, addr_r2, addr_w, data_w,
        output data_r1, data_r2
    );
endinterface
`default_nettype wire

// File: rtl/register_file_32x32_decoder.sv
`default_nettype none
// ============================================================================
// register_file_32x32_decoder : write-address one-hot decoder gated by enable.
// Rev 1.0
// ============================================================================
module register_file_32x32_decoder
    import register_file_32x32_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_INDEX_LIMIT + 1,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  wire logic              en,
    input  wire logic [ADDR_W-1:0] addr,
    output logic      [DEPTH-1:0]  sel
);
    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/register_file_32x32_mux.sv
`default_nettype none
// ============================================================================
// register_file_32x32_mux : DEPTH-to-1 word select feeding a read port.
// Rev 1.0
// ============================================================================
module register_file_32x32_mux
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_W = DATA_INDEX_LIMIT + 1,
    parameter int ADDR_W = REG_ADDR_INDEX_LIMIT + 1,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  wire logic [DEPTH-1:0][DATA_W-1:0] words,
    input  wire logic [ADDR_W-1:0]            sel,
    output logic      [DATA_W-1:0]            out
);
    always_comb begin
        out = words[sel];
    end
endmodule
`default_nettype wire

// File: rtl/register_file_32x32_reg.sv
`default_nettype none
// ============================================================================
// register_file_32x32_reg : async-reset, load-enable storage word.
// Rev 1.0
// ============================================================================
module register_file_32x32_reg
    import register_file_32x32_pkg::*;
#(
    parameter int WIDTH = DATA_INDEX_LIMIT + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// register_file_32x32 : 32x32 register file, one synchronous write port and
// two registered read ports (read-before-write, no bypass).  Rev 1.0
// ============================================================================
module register_file_32x32
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_W   = DATA_INDEX_LIMIT + 1,
    parameter int ADDR_W   = REG_ADDR_INDEX_LIMIT + 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    register_file_32x32_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]             w_write_sel;
    logic [DEPTH-1:0][DATA_W-1:0] w_words;
    logic [DATA_W-1:0]            w_mux_r1;
    logic [DATA_W-1:0]            w_mux_r2;
    logic [DATA_W-1:0]            r_data_r1;
    logic [DATA_W-1:0]            r_data_r2;

    register_file_32x32_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_write_dec (
        .en   (bus.write),
        .addr (bus.addr_w),
        .sel  (w_write_sel)
    );

    // With ZERO_REG set, entry 0 never loads, so reset keeps it at zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic w_load;
        assign w_load = w_write_sel[i] && !((i == 0) && (ZERO_REG != 0));

        register_file_32x32_reg #(
            .WIDTH (DATA_W)
        ) u_word (
            .clk (clk),
            .rst (rst),
            .en  (w_load),
            .d   (bus.data_w),
            .q   (w_words[i])
        );
    end

    register_file_32x32_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mux_r1 (
        .words (w_words),
        .sel   (bus.addr_r1),
        .out   (w_mux_r1)
    );

    register_file_32x32_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mux_r2 (
        .words (w_words),
        .sel   (bus.addr_r2),
        .out   (w_mux_r2)
    );

    // Mux sees pre-edge storage contents, giving read-before-write on a shared edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
        end else if (bus.read) begin
            r_data_r1 <= w_mux_r1;
            r_data_r2 <= w_mux_r2;
        end
    end

    assign bus.data_r1 = r_data_r1;
    assign bus.data_r2 = r_data_r2;
endmodule
`default_nettype wire
